// File: rtl/conv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : conv_pkg                                               |
// | Description : Shared types and helpers for the conv window sequencer |
// |               (state encoding, default word width, size helpers).    |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package conv_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        DRAIN = 3'd2,
        ISSUE = 3'd3,
        WAIT  = 3'd4,
        WRITE = 3'd5,
        DONE  = 3'd6
    } state_t;

    // Number of window positions along one side of the output map.
    function automatic int out_dim(input int in_size, input int filt, input int stride);
        return (in_size - filt) / stride + 1;
    endfunction

    // Address width able to index n entries; never narrower than one bit.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_window_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface   : conv_window_sequencer_if                               |
// | Description : Control, input-RAM, engine and output-RAM signals of   |
// |               the conv window sequencer.                             |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
interface conv_window_sequencer_if #(
    parameter int INPUT_SIZE  = 7,
    parameter int FILTER_SIZE = 3,
    parameter int STRIDE      = 2,
    parameter int DATA_W      = 32
) ();
    import conv_pkg::*;

    localparam int c_NWIN    = FILTER_SIZE * FILTER_SIZE;
    localparam int c_OUT_DIM = out_dim(INPUT_SIZE, FILTER_SIZE, STRIDE);
    localparam int c_IN_AW   = addr_w(INPUT_SIZE * INPUT_SIZE);
    localparam int c_OUT_AW  = addr_w(c_OUT_DIM * c_OUT_DIM);

    logic                       start;
    logic                       busy;
    logic                       done;
    logic                       in_rd_en;
    logic [c_IN_AW-1:0]         in_addr;
    logic [DATA_W-1:0]          in_rd_data;
    logic                       conv_valid;
    logic                       conv_ready;
    logic [c_NWIN*DATA_W-1:0]   conv_window;
    logic                       res_valid;
    logic [DATA_W-1:0]          res_data;
    logic                       out_wr_en;
    logic [c_OUT_AW-1:0]        out_addr;
    logic [DATA_W-1:0]          out_wr_data;

    // Sequencer side.
    modport master (
        input  start, in_rd_data, conv_ready, res_valid, res_data,
        output busy, done, in_rd_en, in_addr, conv_valid, conv_window,
               out_wr_en, out_addr, out_wr_data
    );

    // Environment side: RAMs, engine and controller.
    modport slave (
        output start, in_rd_data, conv_ready, res_valid, res_data,
        input  busy, done, in_rd_en, in_addr, conv_valid, conv_window,
               out_wr_en, out_addr, out_wr_data
    );

endinterface
`default_nettype wire

// File: rtl/conv_window_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : conv_window_addr_gen                                   |
// | Description : Window position (row/col) and in-window (r/c) counters |
// |               producing input-RAM read addresses, the output index   |
// |               and last-window / last-fetch flags.                    |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module conv_window_addr_gen #(
    parameter int INPUT_SIZE  = 7,
    parameter int FILTER_SIZE = 3,
    parameter int STRIDE      = 2,
    parameter int IN_AW       = conv_pkg::addr_w(INPUT_SIZE * INPUT_SIZE),
    parameter int OUT_AW      = conv_pkg::addr_w(conv_pkg::out_dim(INPUT_SIZE, FILTER_SIZE, STRIDE)
                                                 * conv_pkg::out_dim(INPUT_SIZE, FILTER_SIZE, STRIDE)),
    parameter int WIDX_W      = conv_pkg::addr_w(FILTER_SIZE * FILTER_SIZE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              step,
    input  logic              advance,
    output logic [IN_AW-1:0]  in_addr,
    output logic [OUT_AW-1:0] out_addr,
    output logic [WIDX_W-1:0] win_idx,
    output logic              fetch_last,
    output logic              last_win
);
    import conv_pkg::*;

    // Position counters must hold INPUT_SIZE + STRIDE, the largest value
    // compared while deciding whether the next window still fits.
    localparam int c_PW  = addr_w(INPUT_SIZE + STRIDE + 1);
    localparam int c_FW  = addr_w(FILTER_SIZE);

    localparam logic [c_PW-1:0] c_STEP = c_PW'(STRIDE);
    localparam logic [c_PW-1:0] c_K    = c_PW'(FILTER_SIZE);
    localparam logic [c_PW-1:0] c_N    = c_PW'(INPUT_SIZE);
    localparam logic [c_FW-1:0] c_KM1  = c_FW'(FILTER_SIZE - 1);

    logic [c_PW-1:0]   r_row;
    logic [c_PW-1:0]   r_col;
    logic [c_FW-1:0]   r_r;
    logic [c_FW-1:0]   r_c;
    logic [OUT_AW-1:0] r_out_idx;

    logic [c_PW-1:0]   w_col_next;
    logic              w_col_wrap;

    assign w_col_next = r_col + c_STEP;
    assign w_col_wrap = (w_col_next + c_K) > c_N;

    assign in_addr    = (IN_AW'(r_row) + IN_AW'(r_r)) * IN_AW'(INPUT_SIZE)
                      + IN_AW'(r_col) + IN_AW'(r_c);
    assign out_addr   = r_out_idx;
    assign win_idx    = WIDX_W'(r_r) * WIDX_W'(FILTER_SIZE) + WIDX_W'(r_c);
    assign fetch_last = (r_r == c_KM1) && (r_c == c_KM1);
    assign last_win   = ((r_row + c_STEP + c_K) > c_N) && w_col_wrap;

    // Walk r/c across the window during fetch; step the window in raster order after each write.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_row     <= '0;
            r_col     <= '0;
            r_r       <= '0;
            r_c       <= '0;
            r_out_idx <= '0;
        end else begin
            if (step) begin
                if (r_c == c_KM1) begin
                    r_c <= '0;
                    r_r <= (r_r == c_KM1) ? '0 : r_r + c_FW'(1);
                end else begin
                    r_c <= r_c + c_FW'(1);
                end
            end
            if (advance) begin
                r_out_idx <= r_out_idx + OUT_AW'(1);
                if (w_col_wrap) begin
                    r_col <= '0;
                    r_row <= r_row + c_STEP;
                end else begin
                    r_col <= w_col_next;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv_window_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : conv_window_sequencer                                  |
// | Description : Time-multiplexes one conv engine over every strided    |
// |               window of a feature map: fetch window, hand it to the  |
// |               engine, wait for the result, write it out.             |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module conv_window_sequencer #(
    parameter int INPUT_SIZE  = 7,
    parameter int FILTER_SIZE = 3,
    parameter int STRIDE      = 2,
    parameter int DATA_W      = conv_pkg::DATA_W
) (
    input  logic                    clk,
    input  logic                    rst,
    conv_window_sequencer_if.master bus
);
    import conv_pkg::*;

    localparam int c_NWIN    = FILTER_SIZE * FILTER_SIZE;
    localparam int c_OUT_DIM = out_dim(INPUT_SIZE, FILTER_SIZE, STRIDE);
    localparam int c_IN_AW   = addr_w(INPUT_SIZE * INPUT_SIZE);
    localparam int c_OUT_AW  = addr_w(c_OUT_DIM * c_OUT_DIM);
    localparam int c_WIDX_W  = addr_w(c_NWIN);

    state_t                   r_state;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_in_rd_en;
    logic                     r_conv_valid;
    logic                     r_out_wr_en;
    logic [DATA_W-1:0]        r_out_wr_data;

    logic [DATA_W-1:0]        r_window [c_NWIN];
    logic                     r_cap_en;
    logic [c_WIDX_W-1:0]      r_cap_idx;

    logic                     w_clear;
    logic                     w_step;
    logic                     w_advance;
    logic [c_IN_AW-1:0]       w_in_addr;
    logic [c_OUT_AW-1:0]      w_out_addr;
    logic [c_WIDX_W-1:0]      w_win_idx;
    logic                     w_fetch_last;
    logic                     w_last_win;
    logic [c_NWIN*DATA_W-1:0] w_window_flat;

    assign w_clear   = (r_state == IDLE) && bus.start;
    assign w_step    = (r_state == FETCH);
    assign w_advance = (r_state == WRITE);

    conv_window_addr_gen #(
        .INPUT_SIZE  (INPUT_SIZE),
        .FILTER_SIZE (FILTER_SIZE),
        .STRIDE      (STRIDE),
        .IN_AW       (c_IN_AW),
        .OUT_AW      (c_OUT_AW),
        .WIDX_W      (c_WIDX_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .clear      (w_clear),
        .step       (w_step),
        .advance    (w_advance),
        .in_addr    (w_in_addr),
        .out_addr   (w_out_addr),
        .win_idx    (w_win_idx),
        .fetch_last (w_fetch_last),
        .last_win   (w_last_win)
    );

    // Main sequencing FSM; every control output is a register set on the transition into its state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_in_rd_en    <= 1'b0;
            r_conv_valid  <= 1'b0;
            r_out_wr_en   <= 1'b0;
            r_out_wr_data <= '0;
        end else begin
            r_done      <= 1'b0;
            r_out_wr_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state    <= FETCH;
                        r_busy     <= 1'b1;
                        r_in_rd_en <= 1'b1;
                    end
                end
                FETCH: begin
                    if (w_fetch_last) begin
                        r_state    <= DRAIN;
                        r_in_rd_en <= 1'b0;
                    end
                end
                DRAIN: begin
                    r_state      <= ISSUE;
                    r_conv_valid <= 1'b1;
                end
                ISSUE: begin
                    if (bus.conv_ready) begin
                        r_state      <= WAIT;
                        r_conv_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    if (bus.res_valid) begin
                        r_state       <= WRITE;
                        r_out_wr_en   <= 1'b1;
                        r_out_wr_data <= bus.res_data;
                    end
                end
                WRITE: begin
                    if (w_last_win) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state    <= FETCH;
                        r_in_rd_en <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // RAM data lags its read by one cycle, so each read's slot index is delayed alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cap_en  <= 1'b0;
            r_cap_idx <= '0;
            for (int i = 0; i < c_NWIN; i++) begin
                r_window[i] <= '0;
            end
        end else begin
            r_cap_en  <= r_in_rd_en;
            r_cap_idx <= w_win_idx;
            if (r_cap_en) begin
                r_window[r_cap_idx] <= bus.in_rd_data;
            end
        end
    end

    for (genvar gi = 0; gi < c_NWIN; gi++) begin : g_pack
        assign w_window_flat[gi*DATA_W +: DATA_W] = r_window[gi];
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.in_rd_en    = r_in_rd_en;
    assign bus.in_addr     = w_in_addr;
    assign bus.conv_valid  = r_conv_valid;
    assign bus.conv_window = w_window_flat;
    assign bus.out_wr_en   = r_out_wr_en;
    assign bus.out_addr    = w_out_addr;
    assign bus.out_wr_data = r_out_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_conv_window_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_conv_window_sequencer                               |
// | Description : Directed self-checking bench for conv_window_sequencer |
// |               (7x7 map, 3x3 filter, stride 2, word i holds i, engine |
// |               returns the window sum).                               |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_conv_window_sequencer;

    localparam int WW = 9 * 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    conv_window_sequencer_if #(
        .INPUT_SIZE(7), .FILTER_SIZE(3), .STRIDE(2), .DATA_W(32)
    ) bus ();

    conv_window_sequencer #(
        .INPUT_SIZE(7), .FILTER_SIZE(3), .STRIDE(2), .DATA_W(32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Hand-computed window sums: 9*(row*7+col) + 72 for the nine window origins.
    logic [31:0] exp_out [9] = '{32'd72, 32'd90, 32'd108, 32'd198, 32'd216,
                                 32'd234, 32'd324, 32'd342, 32'd360};
    int          exp_rd0 [9] = '{0, 1, 2, 7, 8, 9, 14, 15, 16};

    // Input RAM: word i holds i, one-cycle read latency.
    always @(posedge clk) begin
        if (bus.in_rd_en) bus.in_rd_data <= 32'(bus.in_addr);
    end

    // Engine model: sum of the window, result eng_lat cycles after the handshake.
    int          eng_lat  = 1;
    int          eng_cnt  = 0;
    logic [31:0] eng_sum  = '0;
    logic [31:0] eng_rd   = '0;
    logic        eng_rv   = 1'b0;
    logic        stray_rv = 1'b0;

    function automatic logic [31:0] wsum(input logic [WW-1:0] w);
        logic [31:0] s;
        s = '0;
        for (int k = 0; k < 9; k++) s += w[k*32 +: 32];
        return s;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            eng_rv  <= 1'b0;
            eng_cnt <= 0;
        end else begin
            eng_rv <= 1'b0;
            if (eng_cnt > 0) begin
                if (eng_cnt == 1) begin
                    eng_rv <= 1'b1;
                    eng_rd <= eng_sum;
                end
                eng_cnt <= eng_cnt - 1;
            end
            if (bus.conv_valid && bus.conv_ready) begin
                if (eng_lat <= 1) begin
                    eng_rv <= 1'b1;
                    eng_rd <= wsum(bus.conv_window);
                end else begin
                    eng_cnt <= eng_lat - 1;
                    eng_sum <= wsum(bus.conv_window);
                end
            end
        end
    end

    assign bus.res_valid = eng_rv | stray_rv;
    assign bus.res_data  = stray_rv ? 32'hDEAD_BEEF : eng_rd;

    // Monitors, sampled on the falling edge.
    int          cyc = 0;
    int          n_rd = 0, n_wr = 0, n_done = 0;
    int          rd_log [128];
    int          wr_addr_log [16];
    logic [31:0] wr_data_log [16];
    int          wr_cyc_log [16];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.in_rd_en) begin
                if (n_rd < 128) rd_log[n_rd] = int'(bus.in_addr);
                n_rd++;
            end
            if (bus.out_wr_en) begin
                if (n_wr < 16) begin
                    wr_addr_log[n_wr] = int'(bus.out_addr);
                    wr_data_log[n_wr] = bus.out_wr_data;
                    wr_cyc_log[n_wr]  = cyc;
                end
                n_wr++;
            end
            if (bus.done) n_done++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_wide(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        n_rd   = 0;
        n_wr   = 0;
        n_done = 0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (bus.done) seen = 1'b1;
        end
    endtask

    task automatic check_results(input string pfx);
        check($sformatf("%s_wr_count", pfx), n_wr, 9);
        for (int k = 0; k < 9; k++) begin
            check($sformatf("%s_addr%0d", pfx, k), wr_addr_log[k], k);
            check($sformatf("%s_data%0d", pfx, k), wr_data_log[k], exp_out[k]);
        end
    endtask

    bit             seen;
    bit             found;
    logic [WW-1:0]  held_win;
    logic [WW-1:0]  exp_win0;

    initial begin
        bus.start      = 1'b0;
        bus.conv_ready = 1'b1;
        for (int k = 0; k < 9; k++) exp_win0[k*32 +: 32] = 32'(exp_rd0[k]);

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_rd_en", bus.in_rd_en, 0);
        check("rst_in_addr", bus.in_addr, 0);
        check("rst_conv_valid", bus.conv_valid, 0);
        check("rst_wr_en", bus.out_wr_en, 0);
        check("rst_out_addr", bus.out_addr, 0);
        check("rst_wr_data", bus.out_wr_data, 0);
        check_wide("rst_window", bus.conv_window, '0);
        rst = 1'b0;
        tick();

        // Pass 1: full pass, start re-asserted while busy and during DONE
        clear_logs();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("p1_busy_after_start", bus.busy, 1);
        check("p1_first_rd_en", bus.in_rd_en, 1);
        check("p1_first_addr", bus.in_addr, 0);
        bus.start = 1'b1;
        repeat (3) tick();
        bus.start = 1'b0;
        wait_done(400, seen);
        check("p1_done_seen", seen, 1);
        check("p1_busy_in_done", bus.busy, 0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("p1_done_one_cycle", bus.done, 0);
        repeat (5) tick();
        check("p1_busy_idle", bus.busy, 0);
        check("p1_done_count", n_done, 1);
        check_results("p1");
        for (int k = 0; k < 9; k++) check($sformatf("p1_rd%0d", k), rd_log[k], exp_rd0[k]);
        check("p1_win1_start", rd_log[9], 2);
        check("p1_win3_start", rd_log[27], 14);
        check("p1_win_cycles", wr_cyc_log[1] - wr_cyc_log[0], 13);

        // Pass 2: backpressure on window 0, 10-cycle result latency, stray res_valid in FETCH
        clear_logs();
        eng_lat        = 10;
        bus.conv_ready = 1'b0;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (bus.conv_valid) found = 1'b1;
            else tick();
        end
        check("p2_issue_reached", found, 1);
        held_win = bus.conv_window;
        check_wide("p2_win0", held_win, exp_win0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("p2_valid_held%0d", i), bus.conv_valid, 1);
            check_wide($sformatf("p2_win_stable%0d", i), bus.conv_window, held_win);
        end
        bus.conv_ready = 1'b1;
        tick();
        check("p2_valid_drop", bus.conv_valid, 0);
        repeat (8) tick();
        check("p2_no_early_write", n_wr, 0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (n_wr == 1) found = 1'b1;
        end
        check("p2_late_write", found, 1);
        repeat (2) tick();
        stray_rv = 1'b1;
        tick();
        stray_rv = 1'b0;
        wait_done(600, seen);
        check("p2_done_seen", seen, 1);
        tick();
        check_results("p2");
        check("p2_win_cycles", wr_cyc_log[2] - wr_cyc_log[1], 22);

        // Pass 3: reset while waiting on the result of window 4
        clear_logs();
        eng_lat   = 5;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            tick();
            if (n_wr == 4 && bus.conv_valid) found = 1'b1;
        end
        check("p3_w4_issue", found, 1);
        tick();
        check("p3_in_wait", bus.conv_valid, 0);
        rst = 1'b1;
        tick();
        check("p3_rst_busy", bus.busy, 0);
        check("p3_rst_done", bus.done, 0);
        check("p3_rst_rd_en", bus.in_rd_en, 0);
        check("p3_rst_in_addr", bus.in_addr, 0);
        check("p3_rst_conv_valid", bus.conv_valid, 0);
        check("p3_rst_wr_en", bus.out_wr_en, 0);
        check("p3_rst_out_addr", bus.out_addr, 0);
        check("p3_rst_wr_data", bus.out_wr_data, 0);
        check_wide("p3_rst_window", bus.conv_window, '0);
        rst = 1'b0;
        repeat (20) tick();
        check("p3_no_done", n_done, 0);
        check("p3_writes_frozen", n_wr, 4);
        check("p3_idle_busy", bus.busy, 0);

        // Pass 4: clean pass after the abort
        clear_logs();
        eng_lat   = 1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(400, seen);
        check("p4_done_seen", seen, 1);
        tick();
        check("p4_done_count", n_done, 1);
        check_results("p4");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
